// File: rtl/async_fifo_write_arbiter.sv
// async_fifo_write_arbiter
// Round-robin, burst-limited arbiter sharing one async FIFO write port among
// NUM_REQ producers in the write clock domain. A grant lasts until the
// granted requester's last word, MAX_BURST accepted words, or its valid drop,
// followed by exactly one idle bubble cycle before the next grant.
//
// Optional build macro: ASYNC_FIFO_ARB_STATS_EN adds p_stat_count, one
// saturating 16-bit accepted-word counter per requester.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant held; round-robin pick among valid requesters
// GRANT | requester grant_q owns the FIFO write port
module async_fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                          write_clk,
  input  logic                          write_rst,
  input  logic [NUM_REQ-1:0]            p_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] p_req_data,
  input  logic [NUM_REQ-1:0]            p_req_last,
  output logic [NUM_REQ-1:0]            p_req_ready,
  input  logic                          p_write_full,
  output logic                          p_write_en,
  output logic [DATA_WIDTH-1:0]         p_write_data,
  output logic [$clog2(NUM_REQ)-1:0]    p_grant_id,
  output logic                          p_busy
`ifdef ASYNC_FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         p_stat_count
`endif
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            accept;
  logic            burst_end;

  // First valid index searching upward from the requester after lg, wrapping.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [GW-1:0]      lg);
    logic [GW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(lg) + k) % NUM_REQ;
      if (!found && v[idx]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
    return sel;
  endfunction

  // Handshake outputs decoded from the held grant and the live inputs.
  always_comb begin
    p_busy       = (state_q == GRANT);
    p_req_ready  = '0;
    if (p_busy && !p_write_full) p_req_ready = NUM_REQ'(1) << grant_q;
    accept       = p_busy && !p_write_full && p_req_valid[grant_q];
    p_write_en   = accept;
    p_write_data = p_req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    p_grant_id   = grant_q;
    burst_end    = (burst_cnt_q == BW'(MAX_BURST - 1));
  end

  // Next-state logic: arbitrate in IDLE, count and release in GRANT.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (|p_req_valid) begin
          state_d     = GRANT;
          grant_d     = rr_pick(p_req_valid, last_grant_q);
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        // A dropped valid releases even while the FIFO is full.
        if (!p_req_valid[grant_q] || (accept && (p_req_last[grant_q] || burst_end))) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
          burst_cnt_d  = '0;
        end else if (accept) begin
          burst_cnt_d = burst_cnt_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any burst in progress.
  always_ff @(posedge write_clk or posedge write_rst) begin
    if (write_rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

`ifdef ASYNC_FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [15:0] stat_q;

    // Saturating count of words accepted from requester i.
    always_ff @(posedge write_clk or posedge write_rst) begin
      if (write_rst) begin
        stat_q <= '0;
      end else if (accept && (grant_q == GW'(i)) && (stat_q != 16'hFFFF)) begin
        stat_q <= stat_q + 16'd1;
      end
    end

    assign p_stat_count[i*16 +: 16] = stat_q;
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
